conversor_bcd_binario: RTL

//  Sequential BCD-to-binary converter for the scoreboard datapath; inverse of the binary->BCD score converter.

---
 rtl/conversor_bcd_binario.sv | 121 ++++++++++++
 1 files changed

// File: rtl/conversor_bcd_binario.sv
// Serial BCD-to-binary converter (reverse double-dabble, one result bit per clock).
// Optional invalid-digit rejection is compiled in with `define BCD_CHECK_INVALID_EN.
module conversor_bcd_binario #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  erro
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  logic [SH_W-1:0]    shreg_q;
  logic [SH_W-1:0]    shreg_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [BIN_W-1:0]   bin_out_q;
  logic               erro_q;
  logic               operand_bad;

  // One reverse double-dabble step: shift right, then pull every BCD field >= 8 back by 3.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] s;
    s = v >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[BIN_W + 4*i +: 4] >= 4'd8) begin
        s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
    return s;
  endfunction

`ifdef BCD_CHECK_INVALID_EN
  function automatic logic has_invalid_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  assign operand_bad = has_invalid_digit(bcd_in);
`else
  assign operand_bad = 1'b0;
`endif

  always_comb begin
    shreg_d = dabble_step(shreg_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_out_q <= '0;
      erro_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (operand_bad) begin
              // Rejected operand: report immediately without entering the shift phase.
              bin_out_q <= '0;
              erro_q    <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              shreg_q <= {bcd_in, {BIN_W{1'b0}}};
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              erro_q  <= 1'b0;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            bin_out_q <= shreg_d[BIN_W-1:0];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_out_q;
  assign erro    = erro_q;

endmodule
